// File: rtl/adc_sample_framer.sv
// adc_sample_framer
// Buffers a free-running stream of ADC samples in a FIFO. Once a full
// frame's worth of samples is present, it emits a fixed-length frame:
// MAGIC, sequence number, then FRAME_WORDS payload words (oldest first),
// with m_last on the final payload word.
//
// Ports:
//   clk        system clock; all logic on the rising edge
//   rst        synchronous active-high reset
//   enable     1 = accept samples, 0 = ignore s_valid (frame in flight completes)
//   s_data     sample word
//   s_valid    single-cycle sample strobe
//   m_data     frame word (registered)
//   m_valid    frame word qualifier (registered)
//   m_last     final payload word marker (registered)
//   seq_num    sequence number of the next frame to be sent
//   drop_count samples rejected on a full FIFO, saturating
//   fifo_level current FIFO occupancy
//
// SEQ_INIT is the value seq_num takes on reset (0 in normal use).
module adc_sample_framer #(
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          FRAME_WORDS = 64,
    parameter int unsigned          FIFO_DEPTH  = 256,
    parameter logic [DATA_W-1:0]    MAGIC       = 32'hA5A5_5A5A,
    parameter logic [31:0]          SEQ_INIT    = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_valid,
    output logic                          m_last,
    output logic [31:0]                   seq_num,
    output logic [15:0]                   drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {IDLE, HDR, SEQ, PAY} state_t;

    state_t              state;
    logic [CW-1:0]       pay_cnt;   // payload words already presented
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                full;
    logic                wr_en;
    logic                rd_en;

    // Full is judged on the registered level only: a read in the same
    // cycle does not make room for a write.
    assign full  = (fifo_level == LW'(FIFO_DEPTH));
    assign wr_en = s_valid && enable && !full;

    // Pops run one cycle ahead of the word on m_data: the pop issued while
    // in SEQ supplies payload word 1, and the final PAY cycle pops nothing.
    assign rd_en = (state == SEQ) ||
                   ((state == PAY) && (pay_cnt != CW'(FRAME_WORDS)));

    // Sample storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Pointers, level and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_count <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (s_valid && enable && full && (drop_count != '1)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Framing FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pay_cnt <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            seq_num <= SEQ_INIT;
        end else begin
            case (state)
                IDLE: begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    if (fifo_level >= LW'(FRAME_WORDS)) begin
                        state   <= HDR;
                        m_data  <= MAGIC;
                        m_valid <= 1'b1;
                    end
                end
                HDR: begin
                    state   <= SEQ;
                    m_data  <= seq_num;
                    m_valid <= 1'b1;
                end
                SEQ: begin
                    state   <= PAY;
                    m_data  <= mem[rd_ptr];
                    m_valid <= 1'b1;
                    m_last  <= (FRAME_WORDS == 1);
                    pay_cnt <= CW'(1);
                end
                PAY: begin
                    if (pay_cnt == CW'(FRAME_WORDS)) begin
                        state   <= IDLE;
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        seq_num <= seq_num + 32'd1;
                    end else begin
                        m_data  <= mem[rd_ptr];
                        m_valid <= 1'b1;
                        m_last  <= (pay_cnt == CW'(FRAME_WORDS - 1));
                        pay_cnt <= pay_cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_framer.sv
// Testbench for adc_sample_framer with FRAME_WORDS=4, FIFO_DEPTH=8.
// A second instance starts its sequence number at 32'hFFFFFFFF to show
// the sequence word wrapping to 0.
module tb_adc_sample_framer;

    localparam logic [31:0] MAGIC = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;

    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic [31:0] seq_num;
    logic [15:0] drop_count;
    logic [3:0]  fifo_level;

    logic [31:0] w_data;
    logic        w_valid;
    logic        w_last;
    logic [31:0] w_seq;
    logic [15:0] w_drop;
    logic [3:0]  w_level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adc_sample_framer #(
        .DATA_W(32), .FRAME_WORDS(4), .FIFO_DEPTH(8), .MAGIC(MAGIC)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .seq_num(seq_num),
        .drop_count(drop_count), .fifo_level(fifo_level)
    );

    adc_sample_framer #(
        .DATA_W(32), .FRAME_WORDS(4), .FIFO_DEPTH(8), .MAGIC(MAGIC),
        .SEQ_INIT(32'hFFFF_FFFF)
    ) u_wrap (
        .clk(clk), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
        .m_data(w_data), .m_valid(w_valid), .m_last(w_last), .seq_num(w_seq),
        .drop_count(w_drop), .fifo_level(w_level)
    );

    typedef struct {
        logic        sv;
        logic [31:0] sd;
        logic        ev;
        logic [31:0] ed;
        logic        el;
        logic [3:0]  elev;
        logic [31:0] eseq;
    } vec_t;

    function automatic vec_t mkv(logic sv, logic [31:0] sd, logic ev, logic [31:0] ed,
                                 logic el, logic [3:0] elev, logic [31:0] eseq);
        vec_t v;
        v.sv = sv; v.sd = sd; v.ev = ev; v.ed = ed; v.el = el; v.elev = elev; v.eseq = eseq;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; enable = 1'b1; s_data = '0;
        tick();
        chk("rst valid/last/level", {m_valid, m_last, fifo_level}, 64'd0);
        chk("rst data", m_data, 64'd0);
        chk("rst seq/drop", {seq_num, drop_count}, 64'd0);
        rst = 1'b0;
    endtask

    task automatic send(int n, logic [31:0] first, logic en);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1; s_data = first + 32'(i); enable = en;
            tick();
        end
        s_valid = 1'b0;
    endtask

    // Waits for a frame header, then checks the whole frame and the idle gap.
    task automatic expect_frame(string name, logic [31:0] seq, logic [31:0] first);
        int waitc = 0;
        while (m_valid !== 1'b1 && waitc < 40) begin
            tick();
            waitc++;
        end
        if (m_valid !== 1'b1) begin
            chk({name, " start timeout"}, 64'd0, 64'd1);
            return;
        end
        chk({name, " hdr"}, {m_last, m_data}, {1'b0, MAGIC});
        tick();
        chk({name, " seq"}, {m_valid, m_last, m_data}, {2'b10, seq});
        chk({name, " wrap seq"}, {w_valid, w_data}, {1'b1, seq + 32'hFFFF_FFFF});
        for (int k = 0; k < 4; k++) begin
            tick();
            chk({name, " pay"}, {m_valid, m_last, m_data}, {1'b1, (k == 3), first + 32'(k)});
            if (k == 3) chk({name, " wrap last"}, {63'd0, w_last}, 64'd1);
        end
        tick();
        chk({name, " gap"}, {m_valid, m_last}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[11];
        int   vcnt;
        int   maxlev;

        // 1. Basic frame, cycle by cycle
        tbl[0]  = mkv(1, 1, 0, 0,     0, 1, 0);
        tbl[1]  = mkv(1, 2, 0, 0,     0, 2, 0);
        tbl[2]  = mkv(1, 3, 0, 0,     0, 3, 0);
        tbl[3]  = mkv(1, 4, 0, 0,     0, 4, 0);
        tbl[4]  = mkv(0, 0, 1, MAGIC, 0, 4, 0);
        tbl[5]  = mkv(0, 0, 1, 0,     0, 4, 0);
        tbl[6]  = mkv(0, 0, 1, 1,     0, 3, 0);
        tbl[7]  = mkv(0, 0, 1, 2,     0, 2, 0);
        tbl[8]  = mkv(0, 0, 1, 3,     0, 1, 0);
        tbl[9]  = mkv(0, 0, 1, 4,     1, 0, 0);
        tbl[10] = mkv(0, 0, 0, 0,     0, 0, 1);

        do_reset();
        for (int i = 0; i < 11; i++) begin
            s_valid = tbl[i].sv; s_data = tbl[i].sd; enable = 1'b1;
            tick();
            chk($sformatf("basic row %0d", i),
                {m_valid, m_last, fifo_level, (tbl[i].ev ? m_data : 32'd0), seq_num[7:0]},
                {tbl[i].ev, tbl[i].el, tbl[i].elev, (tbl[i].ev ? tbl[i].ed : 32'd0), tbl[i].eseq[7:0]});
        end
        s_valid = 1'b0;

        // 2. Back-to-back frames; wrap instance shows FFFFFFFF, 0, 1
        do_reset();
        fork
            send(12, 101, 1'b1);
            begin
                expect_frame("b2b f0", 0, 101);
                expect_frame("b2b f1", 1, 105);
                expect_frame("b2b f2", 2, 109);
            end
        join
        chk("b2b end", {seq_num, drop_count, fifo_level}, {32'd3, 16'd0, 4'd0});
        chk("wrap end", {w_seq, w_drop, w_level}, {32'd2, 16'd0, 4'd0});

        // 3. Overflow: 20 back-to-back strobes; samples 13,14,19,20 dropped
        do_reset();
        maxlev = 0;
        fork
            begin
                for (int i = 1; i <= 20; i++) begin
                    s_valid = 1'b1; s_data = 32'(i);
                    tick();
                    if (i == 13) chk("ovf full at 13", {fifo_level, drop_count}, {4'd8, 16'd1});
                    if (i == 14) chk("ovf drop with read", {fifo_level, drop_count}, {4'd7, 16'd2});
                end
                s_valid = 1'b0;
            end
            begin
                expect_frame("ovf f0", 0, 1);
                expect_frame("ovf f1", 1, 5);
                expect_frame("ovf f2", 2, 9);
                expect_frame("ovf f3", 3, 15);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    tick();
                    if (int'(fifo_level) > maxlev) maxlev = int'(fifo_level);
                end
            end
        join
        chk("ovf max level", 64'(maxlev), 64'd8);
        chk("ovf drops", {drop_count, fifo_level}, {16'd4, 4'd0});

        // 4. Enable gating
        do_reset();
        send(3, 201, 1'b1);
        send(5, 301, 1'b0);
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_valid === 1'b1) vcnt++;
        end
        chk("gate no frame", 64'(vcnt), 64'd0);
        chk("gate level/drop", {fifo_level, drop_count}, {4'd3, 16'd0});
        send(1, 204, 1'b1);
        expect_frame("gate frame", 0, 201);

        // 5. Disable mid-frame
        do_reset();
        fork
            begin
                send(4, 401, 1'b1);
                tick(); tick(); tick();
                enable = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    s_valid = 1'b1; s_data = 501 + 32'(i);
                    tick();
                end
                s_valid = 1'b0;
            end
            expect_frame("dis frame", 0, 401);
        join
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_valid === 1'b1) vcnt++;
        end
        chk("dis no more frames", 64'(vcnt), 64'd0);
        chk("dis level/drop/seq", {fifo_level, drop_count, seq_num}, {4'd0, 16'd0, 32'd1});

        // 6. Reset during 3rd payload word
        do_reset();
        send(4, 601, 1'b1);
        vcnt = 0;
        while (m_valid !== 1'b1 && vcnt < 40) begin
            tick();
            vcnt++;
        end
        chk("rstmid hdr", {m_valid, m_data}, {1'b1, MAGIC});
        tick(); tick(); tick(); tick();
        chk("rstmid pay3", {m_valid, m_last, m_data}, {2'b10, 32'd603});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid after", {m_valid, m_last, fifo_level, drop_count}, 64'd0);
        chk("rstmid seq", seq_num, 64'd0);
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_valid === 1'b1 || m_last === 1'b1) vcnt++;
        end
        chk("rstmid no last", 64'(vcnt), 64'd0);
        send(4, 701, 1'b1);
        expect_frame("rstmid next", 0, 701);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
